pb_debounce: RTL and testbench
==============================

PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and reset_n.
REQ-002 Parameter WIDTH, default 4, SHALL set the number of pushbutton channels.
REQ-003 Parameter DB_CYCLES, default 1000000 (20 ms at 50 MHz), SHALL set the number of consecutive cycles required to accept a level change; legal range 2..2^CNT_W.
REQ-004 Parameter CNT_W, default 20, SHALL set the width of each per-channel counter.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-006 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 pb_raw  input  WIDTH  asynchronous board pushbuttons, active-low (0 = pressed).
REQ-008 pb_out  output  WIDTH  debounced level, same polarity as pb_raw; drives the pushbutton PIO in_port.
REQ-009 press_pulse  output  WIDTH  one-cycle pulse per channel on an accepted 1->0 change of pb_out.
REQ-010 release_pulse  output  WIDTH  one-cycle pulse per channel on an accepted 0->1 change of pb_out.

Function
REQ-011 Each pb_raw bit SHALL pass through a two-flop synchronizer (sync1, then sync2); no logic SHALL use pb_raw except sync1.
REQ-012 Each channel SHALL be independent: own counter, own stable register, own pulses.
REQ-013 When sync2[i] equals pb_out[i], counter[i] SHALL load 0 on that edge.
REQ-014 When sync2[i] differs from pb_out[i] and counter[i] < DB_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 When sync2[i] differs from pb_out[i] and counter[i] == DB_CYCLES-1, pb_out[i] SHALL load sync2[i] and counter[i] SHALL load 0 on the same edge.
REQ-016 Any return of sync2[i] to pb_out[i] before acceptance (bounce/glitch) SHALL clear counter[i]; the count restarts from 0 at the next difference.
REQ-017 Latency: if pb_raw[i] is first sampled at edge E0 and held, pb_out[i] SHALL change at edge E0+DB_CYCLES+1; no earlier, no later.
REQ-018 press_pulse[i] SHALL be 1 for exactly the cycle following the edge where pb_out[i] went 1->0, else 0; release_pulse[i] likewise for 0->1.
REQ-019 press_pulse[i] and release_pulse[i] SHALL never be 1 in the same cycle.
REQ-020 Simultaneous acceptances on several channels in the same edge SHALL all update and pulse in the same cycle.
REQ-021 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-022 Pulses SHALL be registered outputs; pb_out SHALL be a registered output; no output SHALL depend combinationally on pb_raw.

Reset
REQ-023 While reset_n is 0 at a rising clk edge, sync1, sync2, and pb_out SHALL load all ones (released), all counters SHALL load 0, and press_pulse and release_pulse SHALL load 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count; after release, a held pressed input SHALL require the full REQ-017 latency measured from the first post-reset sampling edge.
REQ-025 Reset asserted in the cycle a pulse is due SHALL suppress that pulse.

Verification (DB_CYCLES=4, WIDTH=4)
REQ-026 Reset, pb_raw=4'hF held -> pb_out=4'hF, press_pulse=release_pulse=0 for 50 cycles.
REQ-027 pb_raw[0] 1->0 sampled at E0, held -> pb_out=4'hE at E5, press_pulse=4'h1 for exactly the cycle after E5; then release 0->1 at E20 -> pb_out=4'hF at E25, release_pulse=4'h1 for one cycle.
REQ-028 pb_raw[1] bounces 0,1,0,1,0 at 2-cycle intervals, then holds 0 -> no change until 4 consecutive differing sync2 samples; pb_out[1] falls exactly 5 edges after the final 1->0 sample; exactly one press_pulse.
REQ-029 pb_raw=4'h0 applied in one cycle -> pb_out=4'h0 at E5 and press_pulse=4'hF for one cycle.
REQ-030 pb_raw[2]=0 held, reset_n=0 for one edge at E3 -> pb_out stays 4'hF, no pulse; pb_out[2] falls at the 6th edge after reset release (E0 = first post-reset sampling edge, plus 4+1).
REQ-031 Random pb_raw toggling with checker -> pb_out only changes after 4 stable sync2 cycles; no coincident press/release; pulse count equals pb_out transition count.

Source files
------------

// File: rtl/pb_debounce.sv
// ---------------------------------------------------------------------------
// pb_debounce
//
// Multi-channel pushbutton debouncer. Each raw, active-low board button is
// brought into the clk domain through a two-flop synchronizer. The
// synchronized level is accepted into pb_out only after it has differed from
// the current pb_out for DB_CYCLES consecutive clock edges. An accepted change
// fires a one-cycle press (1->0) or release (0->1) pulse. Every channel is
// fully independent of the others.
//
// Parameters
//   WIDTH      number of pushbutton channels
//   DB_CYCLES  consecutive differing samples needed to accept a change
//              (legal range 2 .. 2**CNT_W)
//   CNT_W      width of each per-channel stability counter
//
// Ports
//   clk            system clock; all state updates on its rising edge
//   reset_n        synchronous active-low reset
//   pb_raw         asynchronous pushbuttons, active-low (0 = pressed)
//   pb_out         debounced level, same polarity as pb_raw (registered)
//   press_pulse    one-cycle pulse on an accepted 1->0 change (registered)
//   release_pulse  one-cycle pulse on an accepted 0->1 change (registered)
// ---------------------------------------------------------------------------
module pb_debounce #(
  parameter int          WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int          CNT_W     = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pb_raw,
  output logic [WIDTH-1:0] pb_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  // Terminal count: the counter reaches this value after DB_CYCLES-1
  // differing edges, so the DB_CYCLES-th differing edge performs the accept.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0]            pb_out_r;
  logic [WIDTH-1:0]            press_r;
  logic [WIDTH-1:0]            release_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0]            accept_s;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;

  // Per-channel next-count and accept decision from the synchronized level.
  always_comb begin
    accept_s  = '0;
    cnt_nxt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == pb_out_r[i]) begin
        // Level agrees with pb_out (or a bounce returned): restart counting.
        accept_s[i]  = 1'b0;
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == DB_LAST) begin
        // Enough consecutive differing samples: accept, counter back to 0.
        accept_s[i]  = 1'b1;
        cnt_nxt_s[i] = '0;
      end else begin
        // Saturation is impossible: we never increment past DB_LAST.
        accept_s[i]  = 1'b0;
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer, counters, debounced level and edge pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r   <= '1;
      sync2_r   <= '1;
      pb_out_r  <= '1;
      cnt_r     <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      sync1_r   <= pb_raw;
      sync2_r   <= sync1_r;
      cnt_r     <= cnt_nxt_s;
      // On accept pb_out takes sync2, which always differs, i.e. a toggle.
      pb_out_r  <= pb_out_r ^ accept_s;
      // Direction of the accepted change is the newly accepted level.
      press_r   <= accept_s & ~sync2_r;
      release_r <= accept_s &  sync2_r;
    end
  end

  assign pb_out        = pb_out_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: tb/tb_pb_debounce.sv
// ---------------------------------------------------------------------------
// tb_pb_debounce
//
// Scoreboard bench for pb_debounce with WIDTH=4, DB_CYCLES=4, CNT_W=2 (the
// counter is exactly wide enough for its terminal value). For every driven
// cycle the bench predicts the outputs after the coming edge from a sliding
// window of raw samples: a channel flips at edge E when the raw samples taken
// at edges E-DB-1 .. E-2 all differ from the current debounced level. Reset
// edges force the samples seen by the synchronizer back to all ones.
// ---------------------------------------------------------------------------
module tb_pb_debounce;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int CNT_W = 2;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
    bit               rst;
    int               edge_no;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] pb_raw;
  logic [WIDTH-1:0] pb_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] hist_q[$];
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] prev_out;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               edge_no = 0;
  int               chg_edge [WIDTH];
  int               pulse_cnt[WIDTH];
  int               trans_cnt[WIDTH];

  always #5 clk = ~clk;

  pb_debounce #(
    .WIDTH    (WIDTH),
    .DB_CYCLES(DB),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pb_raw       (pb_raw),
    .pb_out       (pb_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // Compare the outputs of the most recent edge against the scoreboard.
  task automatic monitor();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("pb_out",        32'(pb_out),        32'(e.out));
      check_eq("press_pulse",   32'(press_pulse),   32'(e.press));
      check_eq("release_pulse", 32'(release_pulse), 32'(e.rel));
      check_eq("press_and_rel", 32'(press_pulse & release_pulse), 32'd0);
      for (int i = 0; i < WIDTH; i++) begin
        if (!e.rst && (pb_out[i] !== prev_out[i])) begin
          trans_cnt[i]++;
          chg_edge[i] = e.edge_no;
        end
        pulse_cnt[i] += int'(press_pulse[i]) + int'(release_pulse[i]);
      end
      prev_out = pb_out;
    end
  endtask

  // Predict the outputs after the coming edge and queue them.
  task automatic model(input logic [WIDTH-1:0] raw, input logic rst_n);
    exp_t             e;
    logic [WIDTH-1:0] flip;
    int               idx;
    e.edge_no = edge_no;
    e.rst     = !rst_n;
    if (!rst_n) begin
      m_out   = '1;
      e.press = '0;
      e.rel   = '0;
      hist_q[hist_q.size()-1] = '1;
      hist_q.push_back('1);
    end else begin
      flip = '1;
      for (int i = 0; i < WIDTH; i++) begin
        for (int k = 0; k < DB; k++) begin
          idx = hist_q.size() - 2 - k;
          if (hist_q[idx][i] == m_out[i]) flip[i] = 1'b0;
        end
      end
      e.press = flip &  m_out;
      e.rel   = flip & ~m_out;
      m_out   = m_out ^ flip;
      hist_q.push_back(raw);
    end
    while (hist_q.size() > DB + 2) void'(hist_q.pop_front());
    e.out = m_out;
    sb_q.push_back(e);
  endtask

  // One clock cycle: check previous edge, drive inputs, predict next edge.
  task automatic cycle(input logic [WIDTH-1:0] raw, input logic rst_n);
    @(negedge clk);
    monitor();
    pb_raw  = raw;
    reset_n = rst_n;
    edge_no++;
    model(raw, rst_n);
  endtask

  initial begin
    int               e0;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] bounce [9];

    reset_n  = 1'b0;
    pb_raw   = 4'hF;
    m_out    = '1;
    prev_out = '1;
    for (int i = 0; i < DB + 2; i++) hist_q.push_back('1);
    for (int i = 0; i < WIDTH; i++) begin
      chg_edge[i]  = 0;
      pulse_cnt[i] = 0;
      trans_cnt[i] = 0;
    end

    // Reset, then idle released buttons.
    repeat (3)  cycle(4'hF, 1'b0);
    repeat (50) cycle(4'hF, 1'b1);

    // Channel 0 press and release, each with exact latency.
    e0 = edge_no + 1;
    repeat (20) cycle(4'hE, 1'b1);
    check_eq("press0_latency", 32'(chg_edge[0] - e0), 32'd5);
    e0 = edge_no + 1;
    repeat (20) cycle(4'hF, 1'b1);
    check_eq("release0_latency", 32'(chg_edge[0] - e0), 32'd5);

    // Channel 1 bounce 0,1,0,1,0 at 2-cycle intervals then held low.
    bounce = '{4'hD, 4'hD, 4'hF, 4'hF, 4'hD, 4'hD, 4'hF, 4'hF, 4'hD};
    for (int k = 0; k < 9; k++) cycle(bounce[k], 1'b1);
    e0 = edge_no;
    repeat (12) cycle(4'hD, 1'b1);
    check_eq("bounce1_latency", 32'(chg_edge[1] - e0), 32'd5);
    repeat (12) cycle(4'hF, 1'b1);

    // All channels pressed in the same cycle.
    e0 = edge_no + 1;
    repeat (10) cycle(4'h0, 1'b1);
    for (int i = 0; i < WIDTH; i++) check_eq("all_latency", 32'(chg_edge[i] - e0), 32'd5);
    repeat (10) cycle(4'hF, 1'b1);

    // Channel 2 held, reset mid-count at E3: full latency after reset.
    repeat (3) cycle(4'hB, 1'b1);
    cycle(4'hB, 1'b0);
    e0 = edge_no + 1;
    repeat (10) cycle(4'hB, 1'b1);
    check_eq("reset_midcount2", 32'(chg_edge[2] - e0), 32'd5);
    repeat (10) cycle(4'hF, 1'b1);

    // Channel 3: reset on the very edge the press would be accepted.
    repeat (5) cycle(4'h7, 1'b1);
    cycle(4'h7, 1'b0);
    repeat (3) cycle(4'hF, 1'b1);
    repeat (10) cycle(4'hF, 1'b1);

    // Random toggling with rare resets.
    cur = 4'hF;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 4) == 0) cur[i] = ~cur[i];
      cycle(cur, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    // Drain and final scoreboard entry.
    repeat (12) cycle(4'hF, 1'b1);
    @(negedge clk);
    monitor();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < WIDTH; i++)
      check_eq("pulse_vs_transitions", 32'(pulse_cnt[i]), 32'(trans_cnt[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
